// File: rtl/uart_tx_serializer.sv
// UART transmitter: takes one byte per valid/ready handshake and sends it as
// start, 8 data bits LSB-first, optional parity, then 1 or 2 stop bits.
module uart_tx_serializer #(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_valid,
  input  logic [7:0] i_data,
  output logic       o_ready,
  output logic       o_tx,
  output logic       o_busy,
  output logic       o_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST      = CW'(CLKS_PER_BIT - 1);
  localparam logic          PAR_SENSE     = (PARITY_ODD != 0);
  localparam logic          STOP_LAST_IDX = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic          stop_idx_q, stop_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;

  logic bit_end;
  logic last_stop;
  logic ready_c;
  logic xfer;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    shift_d    = shift_q;
    par_d      = par_q;

    bit_end   = (cnt_q == CNT_LAST);
    last_stop = (state_q == S_STOP) && bit_end && (stop_idx_q == STOP_LAST_IDX);
    // The final stop cycle also accepts, so frames can run back-to-back.
    ready_c   = !i_reset && ((state_q == S_IDLE) || last_stop);
    xfer      = i_valid && ready_c;

    if ((state_q == S_IDLE) || bit_end) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (xfer) begin
          state_d = S_START;
          shift_d = i_data;
          par_d   = (^i_data) ^ PAR_SENSE;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d   = S_DATA;
          bit_idx_d = 3'd0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            stop_idx_d = 1'b0;
            state_d    = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d    = S_STOP;
          stop_idx_d = 1'b0;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (stop_idx_q == STOP_LAST_IDX) begin
            if (xfer) begin
              state_d = S_START;
              shift_d = i_data;
              par_d   = (^i_data) ^ PAR_SENSE;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            stop_idx_d = stop_idx_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Line level is decoded from the next state so o_tx is a clean flop output.
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= 3'd0;
      stop_idx_q <= 1'b0;
      shift_q    <= 8'h00;
      par_q      <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
    end
  end

  assign o_ready = ready_c;
  assign o_tx    = tx_q;
  assign o_busy  = busy_q;
  assign o_done  = last_stop && !i_reset;

endmodule
